// File: rtl/debug_cmd_handler.sv
// debug_cmd_handler
//   Device-side responder for the host debug protocol carried over UART.
//   Decodes single-byte commands, loads programs into instruction memory,
//   controls run/step execution through the stall line, and dumps the
//   pipeline latches and the register file back to the host (LSB byte first).
//   Every dump, load and CPU reset is acknowledged with an 'R' (0x52) byte.
//
// Ports
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_rx_data / i_rx_done    received byte and its one-cycle strobe
//   o_tx_data / o_tx_start   byte to transmit and its one-cycle request
//   i_tx_done                one-cycle strobe: transmitter finished a byte
//   i_if_id .. i_mem_wb      pipeline latches to be dumped
//   o_reg_addr / i_reg_data  register file read port (combinational data)
//   i_halt                   program-end indication from the pipeline
//   o_imem_we/addr/data      instruction memory write port
//   o_stall                  1 = pipeline frozen
//   o_cpu_rst                one-cycle pipeline/PC reset pulse
module debug_cmd_handler #(
  parameter int IF_ID_SIZE      = 32,
  parameter int ID_EX_SIZE      = 129,
  parameter int EX_MEM_SIZE     = 77,
  parameter int MEM_WB_SIZE     = 71,
  parameter int NUM_REGISTERS   = 32,
  parameter int SIZE            = 32,
  parameter int MAX_INSTRUCTION = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_done,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  input  logic [IF_ID_SIZE-1:0]  i_if_id,
  input  logic [ID_EX_SIZE-1:0]  i_id_ex,
  input  logic [EX_MEM_SIZE-1:0] i_ex_mem,
  input  logic [MEM_WB_SIZE-1:0] i_mem_wb,
  output logic [4:0]             o_reg_addr,
  input  logic [SIZE-1:0]        i_reg_data,
  input  logic                   i_halt,
  output logic                   o_imem_we,
  output logic [5:0]             o_imem_addr,
  output logic [SIZE-1:0]        o_imem_data,
  output logic                   o_stall,
  output logic                   o_cpu_rst
);

  localparam int IF_ID_BYTES  = (IF_ID_SIZE + 7) / 8;
  localparam int ID_EX_BYTES  = (ID_EX_SIZE + 7) / 8;
  localparam int EX_MEM_BYTES = (EX_MEM_SIZE + 7) / 8;
  localparam int MEM_WB_BYTES = (MEM_WB_SIZE + 7) / 8;
  localparam int REG_BYTES    = SIZE / 8;

  localparam int MAX_AB      = (IF_ID_BYTES > ID_EX_BYTES) ? IF_ID_BYTES : ID_EX_BYTES;
  localparam int MAX_CD      = (EX_MEM_BYTES > MEM_WB_BYTES) ? EX_MEM_BYTES : MEM_WB_BYTES;
  localparam int MAX_LATCH   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int SHIFT_BYTES = (MAX_LATCH > REG_BYTES) ? MAX_LATCH : REG_BYTES;
  localparam int SHIFT_W     = 8 * SHIFT_BYTES;
  localparam int CNT_W       = $clog2(SHIFT_BYTES + 1);

  localparam logic [7:0] CMD_REG_DUMP = 8'h01;
  localparam logic [7:0] CMD_IF_ID    = 8'h02;
  localparam logic [7:0] CMD_ID_EX    = 8'h03;
  localparam logic [7:0] CMD_EX_MEM   = 8'h04;
  localparam logic [7:0] CMD_MEM_WB   = 8'h05;
  localparam logic [7:0] CMD_LOAD     = 8'h07;
  localparam logic [7:0] CMD_CONT     = 8'h08;
  localparam logic [7:0] CMD_STEP     = 8'h09;
  localparam logic [7:0] CMD_STEP_ONE = 8'h0A;
  localparam logic [7:0] CMD_RUN      = 8'h0D;
  localparam logic [7:0] CMD_CPU_RST  = 8'h11;
  localparam logic [7:0] READY_BYTE   = 8'h52;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DECODE,
    ST_LOAD_CNT,
    ST_LOAD_BYTE,
    ST_LOAD_WR,
    ST_SNAP,
    ST_REG_FETCH,
    ST_TX_BYTE,
    ST_TX_WAIT,
    ST_SEND_R,
    ST_R_WAIT
  } state_t;

  typedef enum logic {
    MODE_STEP,
    MODE_CONT
  } mode_t;

  state_t             state_q, state_d;
  mode_t              mode_q, mode_d;
  logic               running_q, running_d;
  logic [7:0]         cmd_q, cmd_d;
  logic               stall_q, stall_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               imem_we_q, imem_we_d;
  logic [5:0]         imem_addr_q, imem_addr_d;
  logic [SIZE-1:0]    imem_data_q, imem_data_d;
  logic [4:0]         reg_addr_q, reg_addr_d;
  logic               cpu_rst_q, cpu_rst_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
  logic [7:0]         load_cnt_q, load_cnt_d;
  logic [7:0]         word_idx_q, word_idx_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [SIZE-1:0]    word_q, word_d;
  logic               step_fire;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    running_d   = running_q;
    cmd_d       = cmd_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    imem_we_d   = 1'b0;
    imem_addr_d = imem_addr_q;
    imem_data_d = imem_data_q;
    reg_addr_d  = reg_addr_q;
    cpu_rst_d   = 1'b0;
    shift_d     = shift_q;
    tx_cnt_d    = tx_cnt_q;
    load_cnt_d  = load_cnt_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    step_fire   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_rx_done) begin
          cmd_d   = i_rx_data;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        state_d = ST_IDLE;
        case (cmd_q)
          CMD_CONT: mode_d    = MODE_CONT;
          CMD_STEP: mode_d    = MODE_STEP;
          CMD_RUN:  running_d = 1'b1;
          CMD_STEP_ONE: begin
            if (running_q && mode_q == MODE_STEP) begin
              step_fire = 1'b1;
            end
          end
          CMD_CPU_RST: begin
            cpu_rst_d = 1'b1;
            running_d = 1'b0;
            state_d   = ST_SEND_R;
          end
          CMD_LOAD: begin
            running_d = 1'b0;
            state_d   = ST_LOAD_CNT;
          end
          CMD_IF_ID, CMD_ID_EX, CMD_EX_MEM, CMD_MEM_WB: begin
            state_d = ST_SNAP;
          end
          CMD_REG_DUMP: begin
            reg_addr_d = '0;
            state_d    = ST_REG_FETCH;
          end
          default: state_d = ST_IDLE;
        endcase
      end

      ST_LOAD_CNT: begin
        if (i_rx_done) begin
          load_cnt_d = i_rx_data;
          word_idx_d = '0;
          byte_idx_d = '0;
          state_d    = (i_rx_data == 8'd0) ? ST_SEND_R : ST_LOAD_BYTE;
        end
      end

      ST_LOAD_BYTE: begin
        if (i_rx_done) begin
          // Shift in from the top so the first (least significant) byte
          // ends up in bits [7:0] after the fourth byte.
          word_d     = {i_rx_data, word_q[SIZE-1:8]};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = ST_LOAD_WR;
          end
        end
      end

      ST_LOAD_WR: begin
        // Words past the end of instruction memory are consumed silently.
        if (32'(word_idx_q) < MAX_INSTRUCTION) begin
          imem_we_d   = 1'b1;
          imem_addr_d = word_idx_q[5:0];
          imem_data_d = word_q;
        end
        word_idx_d = word_idx_q + 8'd1;
        state_d    = (word_idx_q + 8'd1 == load_cnt_q) ? ST_SEND_R : ST_LOAD_BYTE;
      end

      ST_SNAP: begin
        shift_d = '0;
        case (cmd_q)
          CMD_IF_ID: begin
            shift_d[IF_ID_SIZE-1:0] = i_if_id;
            tx_cnt_d                = CNT_W'(IF_ID_BYTES);
          end
          CMD_ID_EX: begin
            shift_d[ID_EX_SIZE-1:0] = i_id_ex;
            tx_cnt_d                = CNT_W'(ID_EX_BYTES);
          end
          CMD_EX_MEM: begin
            shift_d[EX_MEM_SIZE-1:0] = i_ex_mem;
            tx_cnt_d                 = CNT_W'(EX_MEM_BYTES);
          end
          default: begin
            shift_d[MEM_WB_SIZE-1:0] = i_mem_wb;
            tx_cnt_d                 = CNT_W'(MEM_WB_BYTES);
          end
        endcase
        state_d = ST_TX_BYTE;
      end

      ST_REG_FETCH: begin
        // o_reg_addr was registered on entry, so read data is valid here.
        shift_d             = '0;
        shift_d[SIZE-1:0]   = i_reg_data;
        tx_cnt_d            = CNT_W'(REG_BYTES);
        state_d             = ST_TX_BYTE;
      end

      ST_TX_BYTE: begin
        tx_data_d  = shift_q[7:0];
        tx_start_d = 1'b1;
        shift_d    = shift_q >> 8;
        tx_cnt_d   = tx_cnt_q - CNT_W'(1);
        state_d    = ST_TX_WAIT;
      end

      ST_TX_WAIT: begin
        if (i_tx_done) begin
          if (tx_cnt_q != '0) begin
            state_d = ST_TX_BYTE;
          end else if (cmd_q == CMD_REG_DUMP && reg_addr_q != 5'(NUM_REGISTERS - 1)) begin
            reg_addr_d = reg_addr_q + 5'd1;
            state_d    = ST_REG_FETCH;
          end else begin
            state_d = ST_SEND_R;
          end
        end
      end

      ST_SEND_R: begin
        tx_data_d  = READY_BYTE;
        tx_start_d = 1'b1;
        state_d    = ST_R_WAIT;
      end

      ST_R_WAIT: begin
        if (i_tx_done) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Halt wins over a same-cycle run command.
    if (i_halt) begin
      running_d = 1'b0;
    end

    stall_d = !(step_fire || (mode_d == MODE_CONT && running_d));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_STEP;
      running_q   <= 1'b0;
      cmd_q       <= '0;
      stall_q     <= 1'b1;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      imem_data_q <= '0;
      reg_addr_q  <= '0;
      cpu_rst_q   <= 1'b0;
      shift_q     <= '0;
      tx_cnt_q    <= '0;
      load_cnt_q  <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      running_q   <= running_d;
      cmd_q       <= cmd_d;
      stall_q     <= stall_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      imem_we_q   <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      imem_data_q <= imem_data_d;
      reg_addr_q  <= reg_addr_d;
      cpu_rst_q   <= cpu_rst_d;
      shift_q     <= shift_d;
      tx_cnt_q    <= tx_cnt_d;
      load_cnt_q  <= load_cnt_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
    end
  end

  assign o_tx_data   = tx_data_q;
  assign o_tx_start  = tx_start_q;
  assign o_imem_we   = imem_we_q;
  assign o_imem_addr = imem_addr_q;
  assign o_imem_data = imem_data_q;
  assign o_reg_addr  = reg_addr_q;
  assign o_stall     = stall_q;
  assign o_cpu_rst   = cpu_rst_q;

endmodule

// File: tb/tb_debug_cmd_handler.sv
// tb_debug_cmd_handler
//   Directed bench for debug_cmd_handler: reset values, program load,
//   latch and register dumps, snapshot stability, run/step control,
//   CPU reset command, unknown commands and reset during a dump.
module tb_debug_cmd_handler;

  logic         i_clk;
  logic         i_rst_n;
  logic [7:0]   i_rx_data;
  logic         i_rx_done;
  logic [7:0]   o_tx_data;
  logic         o_tx_start;
  logic         i_tx_done;
  logic [31:0]  i_if_id;
  logic [128:0] i_id_ex;
  logic [76:0]  i_ex_mem;
  logic [70:0]  i_mem_wb;
  logic [4:0]   o_reg_addr;
  logic [31:0]  i_reg_data;
  logic         i_halt;
  logic         o_imem_we;
  logic [5:0]   o_imem_addr;
  logic [31:0]  o_imem_data;
  logic         o_stall;
  logic         o_cpu_rst;

  int total = 0;
  int bad   = 0;

  logic [7:0]  txq[$];
  logic [5:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          stall0_cnt  = 0;
  int          cpu_rst_cnt = 0;

  debug_cmd_handler #(
    .IF_ID_SIZE      (32),
    .ID_EX_SIZE      (129),
    .EX_MEM_SIZE     (77),
    .MEM_WB_SIZE     (71),
    .NUM_REGISTERS   (32),
    .SIZE            (32),
    .MAX_INSTRUCTION (64)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rx_data   (i_rx_data),
    .i_rx_done   (i_rx_done),
    .o_tx_data   (o_tx_data),
    .o_tx_start  (o_tx_start),
    .i_tx_done   (i_tx_done),
    .i_if_id     (i_if_id),
    .i_id_ex     (i_id_ex),
    .i_ex_mem    (i_ex_mem),
    .i_mem_wb    (i_mem_wb),
    .o_reg_addr  (o_reg_addr),
    .i_reg_data  (i_reg_data),
    .i_halt      (i_halt),
    .o_imem_we   (o_imem_we),
    .o_imem_addr (o_imem_addr),
    .o_imem_data (o_imem_data),
    .o_stall     (o_stall),
    .o_cpu_rst   (o_cpu_rst)
  );

  // Register file model: register r holds r * 0x01010101.
  assign i_reg_data = {4{3'b000, o_reg_addr}};

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_tx_start) txq.push_back(o_tx_data);
    if (o_imem_we) begin
      wr_addr_q.push_back(o_imem_addr);
      wr_data_q.push_back(o_imem_data);
    end
    if (!o_stall) stall0_cnt++;
    if (o_cpu_rst) cpu_rst_cnt++;
  end

  // UART transmitter model: finishes each byte a few cycles after the request.
  initial begin
    i_tx_done = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_tx_start) begin
        repeat (3) @(posedge i_clk);
        #1 i_tx_done = 1'b1;
        @(posedge i_clk);
        #1 i_tx_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    tick(1);
    i_rx_done = 1'b0;
    tick(3);
  endtask

  task automatic wait_count(input int n);
    int c;
    c = 0;
    while (txq.size() < n && c < 4000) begin
      tick(1);
      c++;
    end
  endtask

  function automatic logic [7:0] txb(input int i);
    if (i < txq.size()) return txq[i];
    return 8'h00;
  endfunction

  initial begin
    int base;
    int base2;
    int s0;
    int c0;
    int w0;
    logic [31:0]  words [3];
    logic [7:0]   exp_if [5];
    logic [7:0]   exp_wb [10];
    logic [128:0] idex0;
    logic [135:0] idex_ext;
    logic [31:0]  wtmp;

    words  = '{32'h3C010003, 32'h3C020001, 32'h00221823};
    exp_if = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h52};
    exp_wb = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h7F, 8'h52};
    idex0  = 129'h1_F0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F;
    idex_ext = {7'b0, idex0};

    i_rst_n   = 1'b0;
    i_rx_data = 8'h00;
    i_rx_done = 1'b0;
    i_if_id   = 32'h0;
    i_id_ex   = '0;
    i_ex_mem  = '0;
    i_mem_wb  = '0;
    i_halt    = 1'b0;
    tick(3);

    // Reset values
    check("rst_stall",     32'(o_stall),     32'd1);
    check("rst_tx_start",  32'(o_tx_start),  32'd0);
    check("rst_tx_data",   32'(o_tx_data),   32'd0);
    check("rst_imem_we",   32'(o_imem_we),   32'd0);
    check("rst_imem_addr", 32'(o_imem_addr), 32'd0);
    check("rst_imem_data", o_imem_data,      32'd0);
    check("rst_reg_addr",  32'(o_reg_addr),  32'd0);
    check("rst_cpu_rst",   32'(o_cpu_rst),   32'd0);
    i_rst_n = 1'b1;
    tick(3);

    // Program load: three words
    base = txq.size();
    s0   = stall0_cnt;
    send_byte(8'h07);
    send_byte(8'h03);
    for (int w = 0; w < 3; w++) begin
      wtmp = words[w];
      for (int b = 0; b < 4; b++) send_byte(wtmp[8*b +: 8]);
    end
    wait_count(base + 1);
    tick(20);
    check("load_nwrites", 32'(wr_addr_q.size()), 32'd3);
    for (int w = 0; w < 3; w++) begin
      check("load_addr", 32'(wr_addr_q[w]), 32'(w));
      check("load_data", wr_data_q[w], words[w]);
    end
    check("load_ntx",   32'(txq.size() - base), 32'd1);
    check("load_ready", 32'(txb(base)), 32'h52);
    check("load_stall", 32'(stall0_cnt - s0), 32'd0);

    // IF/ID dump
    i_if_id = 32'hDEADBEEF;
    base = txq.size();
    send_byte(8'h02);
    wait_count(base + 5);
    tick(20);
    check("ifid_ntx", 32'(txq.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) check("ifid_byte", 32'(txb(base + i)), 32'(exp_if[i]));

    // MEM/WB dump
    i_mem_wb = 71'h7F_0123_4567_89AB_CDEF;
    base = txq.size();
    send_byte(8'h05);
    wait_count(base + 10);
    tick(20);
    check("memwb_ntx", 32'(txq.size() - base), 32'd10);
    for (int i = 0; i < 10; i++) check("memwb_byte", 32'(txb(base + i)), 32'(exp_wb[i]));

    // ID/EX snapshot stability; a command byte mid-dump is dropped
    i_id_ex = idex0;
    base = txq.size();
    send_byte(8'h03);
    wait_count(base + 1);
    i_id_ex = ~idex0;
    send_byte(8'h02);
    wait_count(base + 18);
    tick(40);
    check("idex_ntx", 32'(txq.size() - base), 32'd18);
    for (int i = 0; i < 17; i++) check("idex_byte", 32'(txb(base + i)), 32'(idex_ext[8*i +: 8]));
    check("idex_ready", 32'(txb(base + 17)), 32'h52);

    // CPU reset command
    base = txq.size();
    c0   = cpu_rst_cnt;
    send_byte(8'h11);
    wait_count(base + 1);
    tick(20);
    check("cpurst_pulses", 32'(cpu_rst_cnt - c0), 32'd1);
    check("cpurst_ntx",    32'(txq.size() - base), 32'd1);
    check("cpurst_ready",  32'(txb(base)), 32'h52);

    // Run/step control
    s0 = stall0_cnt;
    send_byte(8'h09);
    send_byte(8'h0D);
    tick(5);
    check("step_run_stall0", 32'(stall0_cnt - s0), 32'd0);
    check("step_run_stall",  32'(o_stall), 32'd1);
    send_byte(8'h0A);
    tick(5);
    check("step_one_pulse", 32'(stall0_cnt - s0), 32'd1);
    check("step_one_after", 32'(o_stall), 32'd1);
    send_byte(8'h08);
    tick(2);
    check("cont_stall", 32'(o_stall), 32'd0);
    i_halt = 1'b1;
    tick(1);
    check("halt_stall", 32'(o_stall), 32'd1);
    i_halt = 1'b0;
    tick(3);
    check("halt_hold", 32'(o_stall), 32'd1);
    send_byte(8'h09);
    s0 = stall0_cnt;
    send_byte(8'h0A);
    tick(5);
    check("step_not_running", 32'(stall0_cnt - s0), 32'd0);

    // Register dump
    base = txq.size();
    send_byte(8'h01);
    wait_count(base + 129);
    tick(40);
    check("reg_ntx", 32'(txq.size() - base), 32'd129);
    for (int r = 0; r < 32; r++)
      for (int b = 0; b < 4; b++)
        check("reg_byte", 32'(txb(base + 4*r + b)), 32'(r));
    check("reg_ready",    32'(txb(base + 128)), 32'h52);
    check("reg_addr_end", 32'(o_reg_addr), 32'd31);

    // Unknown command produces nothing
    base = txq.size();
    send_byte(8'hFF);
    tick(30);
    check("unknown_ntx", 32'(txq.size() - base), 32'd0);

    // Empty load: immediate ready byte, no writes
    base = txq.size();
    w0   = wr_addr_q.size();
    send_byte(8'h07);
    send_byte(8'h00);
    wait_count(base + 1);
    tick(20);
    check("load0_ntx",    32'(txq.size() - base), 32'd1);
    check("load0_ready",  32'(txb(base)), 32'h52);
    check("load0_writes", 32'(wr_addr_q.size() - w0), 32'd0);

    // Reset during byte 5 of an ID/EX dump
    base = txq.size();
    send_byte(8'h03);
    wait_count(base + 5);
    i_rst_n = 1'b0;
    tick(1);
    check("midrst_tx_start", 32'(o_tx_start), 32'd0);
    check("midrst_stall",    32'(o_stall),    32'd1);
    check("midrst_tx_data",  32'(o_tx_data),  32'd0);
    tick(2);
    i_rst_n = 1'b1;
    tick(15);
    check("midrst_ntx", 32'(txq.size() - base), 32'd5);
    base2 = txq.size();
    send_byte(8'h02);
    wait_count(base2 + 5);
    tick(20);
    check("postrst_ntx", 32'(txq.size() - base2), 32'd5);
    for (int i = 0; i < 5; i++) check("postrst_byte", 32'(txb(base2 + i)), 32'(exp_if[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debug_cmd_handler.md
Name: debug_cmd_handler

Overview:
- Device-side responder for the host debug protocol over UART, instantiated inside the mips top between the uart_rx/uart_tx pair and the pipeline.
- Decodes single-byte commands, loads programs into instruction memory, and controls run/step execution through the stall line.
- Dumps the pipeline latches and the register file back to the host, LSB byte first. Every dump and load ends with an 'R' (0x52) ready byte.

Parameters:
IF_ID_SIZE, 32, IF/ID latch width
ID_EX_SIZE, 129, ID/EX latch width
EX_MEM_SIZE, 77, EX/MEM latch width
MEM_WB_SIZE, 71, MEM/WB latch width
NUM_REGISTERS, 32, register file depth
SIZE, 32, data/instruction word width
MAX_INSTRUCTION, 64, instruction memory depth (words)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_rx_data  in  8  byte from uart_rx
i_rx_done  in  1  one-cycle strobe, i_rx_data valid
o_tx_data  out  8  byte to uart_tx
o_tx_start  out  1  one-cycle transmit request
i_tx_done  in  1  one-cycle strobe, uart_tx finished a byte
i_if_id  in  IF_ID_SIZE  IF/ID latch
i_id_ex  in  ID_EX_SIZE  ID/EX latch
i_ex_mem  in  EX_MEM_SIZE  EX/MEM latch
i_mem_wb  in  MEM_WB_SIZE  MEM/WB latch
o_reg_addr  out  5  register file read address
i_reg_data  in  SIZE  combinational register read data
i_halt  in  1  program-end indication from the pipeline
o_imem_we  out  1  instruction memory write enable
o_imem_addr  out  6  instruction word address
o_imem_data  out  SIZE  instruction word
o_stall  out  1  1 = pipeline frozen
o_cpu_rst  out  1  one-cycle pipeline/PC reset pulse

Behaviour:
- Reset: state IDLE, mode = step, running = 0.
  - Output reset values: o_stall=1, o_tx_start=0, o_tx_data=0, o_imem_we=0, o_imem_addr=0, o_imem_data=0, o_reg_addr=0, o_cpu_rst=0.
  - Reset mid-transfer aborts the transfer; no partial byte is re-sent.
- Commands are accepted only in IDLE on i_rx_done. Bytes arriving in any TX state are dropped. Unknown codes are ignored with no reply.
- 0x08: mode = continuous. 0x09: mode = step. Both take effect next cycle, silently.
- 0x0D: running = 1.
- o_stall:
  - Continuous mode: o_stall = !running.
  - Step mode: o_stall = 1, except 0x0A drives o_stall=0 for exactly one cycle when running=1. 0x0A with running=0 does nothing.
  - i_halt=1 clears running; this takes precedence over a same-cycle 0x0D.
- 0x11: o_cpu_rst pulses 1 cycle, running cleared, then 'R' sent.
- 0x07 (load):
  - running cleared and o_stall forced 1 for the whole load.
  - Next byte is N. Then 4N bytes follow, each word assembled LSB-first.
  - After the 4th byte of word k: o_imem_we=1 for one cycle, o_imem_addr=k, o_imem_data=word.
  - Words with k >= MAX_INSTRUCTION are consumed but not written.
  - After the last word (or immediately if N=0), 'R' is sent.
- 0x02/0x03/0x04/0x05 (latch dump):
  - The selected latch is snapshotted into a shift register in the cycle after the command, zero-extended to ceil(W/8)*8 bits.
  - Byte counts: IF/ID 4, ID/EX 17, EX/MEM 10, MEM/WB 9. Bytes are sent LSB first, then 'R'.
  - Latch changes during transmission do not affect the data sent.
- 0x01 (register dump): for r = 0..NUM_REGISTERS-1, set o_reg_addr=r, capture i_reg_data one cycle later, send 4 bytes LSB first. 'R' is sent after the last register.
- TX handshake:
  - Each byte: assert o_tx_start for 1 cycle with o_tx_data stable, then wait for i_tx_done before the next byte.
  - o_tx_data is held until the next o_tx_start.
  - An i_tx_done seen while not waiting is ignored.
- FSM states:
  - IDLE -> DECODE.
  - Load path: LOAD_CNT -> LOAD_BYTE -> LOAD_WR -> (LOAD_BYTE | SEND_R).
  - Latch dump: SNAP -> TX_BYTE -> TX_WAIT -> (TX_BYTE | SEND_R).
  - Register dump: REG_FETCH -> TX_BYTE -> TX_WAIT -> (TX_BYTE | REG_FETCH | SEND_R).
  - SEND_R -> R_WAIT -> IDLE.

Test Plan:
- Load: 0x07, 0x03, words 0x3C010003/0x3C020001/0x00221823 sent LSB-first -> three o_imem_we pulses with addr 0,1,2 and those words; then exactly one 'R'. o_stall=1 throughout.
- Latch dump: i_if_id=0xDEADBEEF, 0x02 -> TX bytes EF BE AD DE 52. i_mem_wb = 71'h7F_0123_4567_89AB_CDEF, 0x05 -> EF CD AB 89 67 45 23 01 7F 52.
- Snapshot stability: during a 0x03 dump, change i_id_ex after byte 0 -> all 17 bytes match the value at command time. A 0x02 received mid-dump is dropped.
- Run/step: 0x09, 0x0D -> o_stall stays 1. Then 0x0A -> exactly one cycle with o_stall=0. Then 0x08 -> o_stall=0 continuously. Assert i_halt -> o_stall=1 next cycle.
- Register dump: reg r holds r*0x01010101, command 0x01 -> 128 bytes where byte 4r..4r+3 = r, then 52. o_reg_addr sweeps 0..31 in order.
- Reset mid-operation: drop i_rst_n low during byte 5 of a 0x03 dump -> o_tx_start=0, o_stall=1, state IDLE. A subsequent 0x02 is serviced normally.
